// File: rtl/uart_mvm_pkg.sv
// Shared constants, element types and FSM encodings for the UART matrix-vector tile.
package uart_mvm_pkg;

   // Serial link timing and framing
   localparam int CLOCKS_PER_PULSE = 10;
   localparam int BITS_PER_WORD    = 8;
   localparam int PACKET_SIZE_TX   = 13;

   // Matrix geometry and element widths
   localparam int R       = 2;
   localparam int C       = 2;
   localparam int W_X     = 4;
   localparam int W_K     = 4;
   localparam int W_Y_OUT = 8;

   // Derived widths
   localparam int W_Y        = W_X + W_K + $clog2(C);
   localparam int W_BUS_KX   = R * C * W_K + C * W_X;
   localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
   localparam int N_WORDS_Y  = R * W_Y_OUT / 8;

   // Counter widths
   localparam int W_PULSE_CNT = $clog2(CLOCKS_PER_PULSE);
   localparam int W_RX_BIT    = $clog2(BITS_PER_WORD);
   localparam int W_TX_BIT    = $clog2(PACKET_SIZE_TX);
   localparam int W_BYTE_CNT  = $clog2(N_WORDS_KX);

   // Signed element types
   typedef logic signed [W_X-1:0] x_elem_t;
   typedef logic signed [W_K-1:0] k_elem_t;
   typedef logic signed [W_Y-1:0] y_elem_t;

   typedef x_elem_t x_vec_t [C];
   typedef k_elem_t k_mat_t [R][C];
   typedef y_elem_t y_vec_t [R];

   // FSM encodings
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   typedef enum logic {
      TX_IDLE,
      TX_SEND
   } tx_state_e;

   // Builds one TX frame, bit 0 first on the wire: start 0, data LSB first, trailing 1s.
   function automatic logic [PACKET_SIZE_TX-1:0] make_tx_frame(input logic [BITS_PER_WORD-1:0] d);
      return {{(PACKET_SIZE_TX - BITS_PER_WORD - 1){1'b1}}, d, 1'b0};
   endfunction

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-clock byte-valid strobe.
// Frames with a low stop bit are dropped silently.
module uart_rx
   import uart_mvm_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   output logic [BITS_PER_WORD-1:0] data,
   output logic                     valid
);

   localparam int HALF_PULSE = CLOCKS_PER_PULSE / 2;

   logic rx_meta, rx_sync, rx_prev;
   logic fall;

   rx_state_e                state, state_nxt;
   logic [W_PULSE_CNT-1:0]   cnt, cnt_nxt;
   logic [W_RX_BIT-1:0]      bit_idx, bit_idx_nxt;
   logic [BITS_PER_WORD-1:0] shreg, shreg_nxt;
   logic [BITS_PER_WORD-1:0] data_nxt;
   logic                     valid_nxt;

   // Synchronize the asynchronous line and keep one extra stage for edge detection.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign fall = rx_prev & ~rx_sync;

   // State and datapath register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         data    <= '0;
         valid   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
         data    <= data_nxt;
         valid   <= valid_nxt;
      end
   end

   // Next-state logic: half a bit to the start-bit centre, then one full bit per sample.
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      data_nxt    = data;
      valid_nxt   = 1'b0;
      case (state)
         RX_IDLE: begin
            if (fall) begin
               state_nxt = RX_START;
               cnt_nxt   = '0;
            end
         end
         RX_START: begin
            if (cnt == W_PULSE_CNT'(HALF_PULSE - 1)) begin
               cnt_nxt = '0;
               if (rx_sync) begin
                  state_nxt = RX_IDLE;
               end else begin
                  state_nxt   = RX_DATA;
                  bit_idx_nxt = '0;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt == W_PULSE_CNT'(CLOCKS_PER_PULSE - 1)) begin
               cnt_nxt   = '0;
               shreg_nxt = {rx_sync, shreg[BITS_PER_WORD-1:1]};
               if (bit_idx == W_RX_BIT'(BITS_PER_WORD - 1)) begin
                  state_nxt = RX_STOP;
               end else begin
                  bit_idx_nxt = bit_idx + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == W_PULSE_CNT'(CLOCKS_PER_PULSE - 1)) begin
               cnt_nxt   = '0;
               state_nxt = RX_IDLE;
               if (rx_sync) begin
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/uart_mvm_top.sv
// Tile top: collects a 3-byte K/X packet over UART, computes the signed 2x2 product
// y = K*x, and returns the low byte of each y element over UART (y0 first).
module uart_mvm_top
   import uart_mvm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int W_RES = N_WORDS_Y * BITS_PER_WORD;

   logic [BITS_PER_WORD-1:0] rx_data;
   logic                     rx_valid;

   logic [W_BYTE_CNT-1:0]    byte_cnt;
   logic [W_BUS_KX-1:0]      bus_kx;
   logic                     pkt_done;

   x_vec_t                   x;
   k_mat_t                   k;
   y_vec_t                   y;

   logic [W_RES-1:0]         res_data;
   logic                     res_full;

   tx_state_e                tx_state, tx_state_nxt;
   logic [PACKET_SIZE_TX-1:0] tx_frame, tx_frame_nxt;
   logic [BITS_PER_WORD-1:0] tx_hi, tx_hi_nxt;
   logic [W_TX_BIT-1:0]      tx_bit, tx_bit_nxt;
   logic [W_PULSE_CNT-1:0]   tx_cnt, tx_cnt_nxt;
   logic                     tx_sel, tx_sel_nxt;
   logic                     tx, tx_nxt;
   logic                     tx_take;

   logic                     unused_ok;

   uart_rx u_rx (
      .clk   (clk),
      .rst   (rst),
      .rx    (ui_in[0]),
      .data  (rx_data),
      .valid (rx_valid)
   );

   // Pack accepted bytes into the K/X bus; flag the packet when the last byte lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         bus_kx   <= '0;
         pkt_done <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         if (rx_valid) begin
            bus_kx[byte_cnt * BITS_PER_WORD +: BITS_PER_WORD] <= rx_data;
            if (byte_cnt == W_BYTE_CNT'(N_WORDS_KX - 1)) begin
               byte_cnt <= '0;
               pkt_done <= 1'b1;
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
      end
   end

   // Unpack the fields and form the signed dot products at full W_Y precision.
   always_comb begin
      for (int c = 0; c < C; c++) begin
         x[c] = bus_kx[c * W_X +: W_X];
      end
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < C; c++) begin
            k[r][c] = bus_kx[C * W_X + (r * C + c) * W_K +: W_K];
         end
      end
      for (int r = 0; r < R; r++) begin
         y[r] = '0;
         for (int c = 0; c < C; c++) begin
            y[r] = y[r] + W_Y'(k[r][c]) * W_Y'(x[c]);
         end
      end
   end

   // Single-entry result buffer; a fresh result overwrites one that has not started sending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_data <= '0;
         res_full <= 1'b0;
      end else begin
         if (pkt_done) begin
            res_data <= {y[1][W_Y_OUT-1:0], y[0][W_Y_OUT-1:0]};
            res_full <= 1'b1;
         end else if (tx_take) begin
            res_full <= 1'b0;
         end
      end
   end

   // TX state and line register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_frame <= '1;
         tx_hi    <= '0;
         tx_bit   <= '0;
         tx_cnt   <= '0;
         tx_sel   <= 1'b0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         tx_frame <= tx_frame_nxt;
         tx_hi    <= tx_hi_nxt;
         tx_bit   <= tx_bit_nxt;
         tx_cnt   <= tx_cnt_nxt;
         tx_sel   <= tx_sel_nxt;
         tx       <= tx_nxt;
      end
   end

   // TX next-state: grab the buffer when idle, shift out y0's frame then y1's frame.
   // tx_nxt always mirrors the frame bit that will be current after the edge.
   always_comb begin
      tx_state_nxt = tx_state;
      tx_frame_nxt = tx_frame;
      tx_hi_nxt    = tx_hi;
      tx_bit_nxt   = tx_bit;
      tx_cnt_nxt   = tx_cnt;
      tx_sel_nxt   = tx_sel;
      tx_nxt       = tx;
      tx_take      = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            tx_nxt = 1'b1;
            if (res_full) begin
               tx_take      = 1'b1;
               tx_hi_nxt    = res_data[W_RES-1 -: BITS_PER_WORD];
               tx_frame_nxt = make_tx_frame(res_data[BITS_PER_WORD-1:0]);
               tx_nxt       = 1'b0;
               tx_bit_nxt   = '0;
               tx_cnt_nxt   = '0;
               tx_sel_nxt   = 1'b0;
               tx_state_nxt = TX_SEND;
            end
         end
         TX_SEND: begin
            if (tx_cnt == W_PULSE_CNT'(CLOCKS_PER_PULSE - 1)) begin
               tx_cnt_nxt = '0;
               if (tx_bit == W_TX_BIT'(PACKET_SIZE_TX - 1)) begin
                  tx_bit_nxt = '0;
                  if (!tx_sel) begin
                     tx_sel_nxt   = 1'b1;
                     tx_frame_nxt = make_tx_frame(tx_hi);
                     tx_nxt       = 1'b0;
                  end else begin
                     tx_state_nxt = TX_IDLE;
                     tx_nxt       = 1'b1;
                  end
               end else begin
                  tx_bit_nxt   = tx_bit + 1'b1;
                  tx_frame_nxt = tx_frame >> 1;
                  tx_nxt       = tx_frame[1];
               end
            end else begin
               tx_cnt_nxt = tx_cnt + 1'b1;
            end
         end
      endcase
   end

   assign uo_out  = {7'b0, tx};
   assign uio_out = '0;
   assign uio_oe  = '0;

   // Inputs with no function in this tile, plus the y sign bits that truncation drops.
   assign unused_ok = &{1'b0, ena, ui_in[7:1], uio_in, y[0][W_Y-1], y[1][W_Y-1]};

endmodule

// File: tb/tb_uart_mvm_top.sv
// Directed bench for uart_mvm_top: drives UART packets on ui_in[0], decodes uo_out[0]
// in a background monitor, and compares against hand-computed and modelled results.
module tb_uart_mvm_top;
   import uart_mvm_pkg::*;

   localparam int CPP = CLOCKS_PER_PULSE;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       ena    = 1'b1;
   logic [7:0] ui_in  = 8'h01;
   logic [7:0] uio_in = 8'h00;
   wire  [7:0] uo_out;
   wire  [7:0] uio_out;
   wire  [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   // Decoded TX bytes: {trailing_bits_all_one, data}
   logic [8:0]  rxq[$];
   logic [15:0] expq[$];

   always #5 clk = ~clk;

   uart_mvm_top dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      ui_in[0] = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      ui_in[0] = 1'b0;
      repeat (CPP) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         ui_in[0] = d[i];
         repeat (CPP) @(negedge clk);
      end
      ui_in[0] = stop_bit;
      repeat (CPP) @(negedge clk);
      ui_in[0] = 1'b1;
   endtask

   function automatic int s4(input logic [3:0] v);
      return v[3] ? int'(v) - 16 : int'(v);
   endfunction

   // Reference model: returns {y1[7:0], y0[7:0]} for bytes b0,b1,b2.
   function automatic logic [15:0] model(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2);
      int x0, x1, y0, y1;
      logic [31:0] t0, t1;
      x0 = s4(b0[3:0]);
      x1 = s4(b0[7:4]);
      y0 = s4(b1[3:0]) * x0 + s4(b1[7:4]) * x1;
      y1 = s4(b2[3:0]) * x0 + s4(b2[7:4]) * x1;
      t0 = y0;
      t1 = y1;
      return {t1[7:0], t0[7:0]};
   endfunction

   task automatic wait_bytes(input string tag, input int need);
      int n;
      n = 0;
      while (rxq.size() < need && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_bytes_ready"}, (rxq.size() >= need) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic expect_pair(input string tag, input logic [7:0] e0, input logic [7:0] e1);
      logic [8:0] r0, r1;
      wait_bytes(tag, 2);
      if (rxq.size() >= 2) begin
         r0 = rxq.pop_front();
         r1 = rxq.pop_front();
         check({tag, "_y0"},    {24'b0, r0[7:0]}, {24'b0, e0});
         check({tag, "_y1"},    {24'b0, r1[7:0]}, {24'b0, e1});
         check({tag, "_stop0"}, {31'b0, r0[8]},   32'd1);
         check({tag, "_stop1"}, {31'b0, r1[8]},   32'd1);
      end
   endtask

   // Background UART decoder on uo_out[0].
   initial begin : tx_monitor
      logic [7:0] d;
      logic       ok;
      forever begin
         @(negedge clk);
         if (!rst && uo_out[0] === 1'b0) begin
            repeat (CPP / 2) @(negedge clk);
            d  = '0;
            ok = 1'b1;
            for (int i = 0; i < 8; i++) begin
               repeat (CPP) @(negedge clk);
               d[i] = uo_out[0];
            end
            for (int i = 0; i < 4; i++) begin
               repeat (CPP) @(negedge clk);
               if (uo_out[0] !== 1'b1) ok = 1'b0;
            end
            rxq.push_back({ok, d});
         end
      end
   end

   initial begin : stimulus
      logic [7:0]  b0, b1, b2;
      logic [15:0] e;
      logic [8:0]  r0, r1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx_during", {24'b0, uo_out}, 32'h01);
      rst = 1'b0;
      idle(5);
      check("rst_uo_out",  {24'b0, uo_out},  32'h01);
      check("rst_uio_out", {24'b0, uio_out}, 32'h00);
      check("rst_uio_oe",  {24'b0, uio_oe},  32'h00);

      // Basic packet, back-to-back bytes
      send_byte(8'h21, 1'b1);
      send_byte(8'h43, 1'b1);
      send_byte(8'h65, 1'b1);
      expect_pair("basic", 8'h0B, 8'h11);
      idle(30);

      // Mixed signs
      send_byte(8'h1F, 1'b1);
      send_byte(8'h32, 1'b1);
      send_byte(8'h7E, 1'b1);
      expect_pair("signed", 8'h01, 8'h09);
      idle(30);

      // Most negative everywhere: y=128 truncates to 0x80
      send_byte(8'h88, 1'b1);
      send_byte(8'h88, 1'b1);
      send_byte(8'h88, 1'b1);
      expect_pair("trunc", 8'h80, 8'h80);
      idle(30);

      // Random packets with random gaps; TX overlaps the following packet's RX
      for (int p = 0; p < 10; p++) begin
         b0 = 8'($urandom);
         b1 = 8'($urandom);
         b2 = 8'($urandom);
         expq.push_back(model(b0, b1, b2));
         send_byte(b0, 1'b1);
         idle($urandom_range(1, 20));
         send_byte(b1, 1'b1);
         idle($urandom_range(1, 20));
         send_byte(b2, 1'b1);
         idle($urandom_range(1, 100));
      end
      wait_bytes("rand", 20);
      for (int p = 0; p < 10; p++) begin
         if (rxq.size() >= 2 && expq.size() >= 1) begin
            e  = expq.pop_front();
            r0 = rxq.pop_front();
            r1 = rxq.pop_front();
            check($sformatf("rand%0d_y0", p), {24'b0, r0[7:0]}, {24'b0, e[7:0]});
            check($sformatf("rand%0d_y1", p), {24'b0, r1[7:0]}, {24'b0, e[15:8]});
            check($sformatf("rand%0d_stop", p), {31'b0, r0[8] & r1[8]}, 32'd1);
         end
      end
      idle(30);

      // Framing error: the bad byte must not advance the byte counter
      send_byte(8'h55, 1'b0);
      idle(20);
      send_byte(8'h21, 1'b1);
      send_byte(8'h43, 1'b1);
      send_byte(8'h65, 1'b1);
      expect_pair("frame_err", 8'h0B, 8'h11);
      idle(300);
      check("frame_err_no_extra", rxq.size(), 32'd0);

      // Reset after two bytes discards the partial packet
      send_byte(8'h21, 1'b1);
      send_byte(8'h43, 1'b1);
      idle(5);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("mid_rst_tx%0d", i), {31'b0, uo_out[0]}, 32'd1);
      end
      rst = 1'b0;
      idle(5);
      send_byte(8'h21, 1'b1);
      send_byte(8'h43, 1'b1);
      send_byte(8'h65, 1'b1);
      expect_pair("after_rst", 8'h0B, 8'h11);
      idle(400);
      check("after_rst_no_extra", rxq.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_mvm_top.md
Name: uart_mvm_top

Overview:
- Top-level TinyTapeout-style tile; computes a signed 2x2 matrix-vector product over a UART link.
- Receives one K/X packet as 8N1 UART bytes on ui_in[0].
- Returns the truncated result vector Y as UART bytes on uo_out[0].
- Fixed-size datapath; no host handshake beyond the serial line.

Parameters:
- CLOCKS_PER_PULSE, 10: clocks per UART bit, both directions.
- BITS_PER_WORD, 8: data bits per UART word.
- PACKET_SIZE_TX, 13: TX frame length in bits = 1 start + 8 data + 4 stop (high).
- R, 2: matrix rows.
- C, 2: matrix columns / vector length.
- W_X, 4: signed X element width.
- W_K, 4: signed K element width.
- W_Y_OUT, 8: transmitted width per Y element.
- Derived: W_Y = W_X+W_K+clog2(C) = 9; W_BUS_KX = R*C*W_K + C*W_X = 24; N_WORDS_KX = 3; N_WORDS_Y = R*W_Y_OUT/8 = 2.

Ports:
- clk  in  1: clock; all state on rising edge.
- rst  in  1: reset, asynchronous, active-high.
- ena  in  1: ignored.
- ui_in  in  8: bit 0 = UART rx (idle high); bits 7:1 unused.
- uio_in  in  8: unused.
- uo_out  out  8: bit 0 = UART tx (idle high); bits 7:1 = 0.
- uio_out  out  8: constant 0.
- uio_oe  out  8: constant 0 (all inputs).

Behaviour:
- Reset values:
  - tx = 1; RX and TX FSMs idle.
  - Byte counter 0; result buffer empty; all registers cleared.
  - Reset mid-frame aborts any partial RX or TX frame.
- RX path:
  - rx passes through a 2-flop synchronizer.
  - FSM states: IDLE -> START -> DATA -> STOP.
  - IDLE: leave on a synchronized falling edge.
  - START: wait CLOCKS_PER_PULSE/2 clocks. If rx is high at the sample, return to IDLE (glitch).
  - DATA: sample 8 bits, one every CLOCKS_PER_PULSE clocks, LSB first.
  - STOP: sample once more. Stop bit = 1: accept byte. Stop bit = 0: framing error; discard byte, counter unchanged.
  - Back-to-back frames with no idle gap must be accepted.
- Packet assembly:
  - Accepted bytes fill a 24-bit bus, byte n into bits [8n+7:8n].
  - After byte 2 the counter wraps to 0 and the packet is complete.
- Field mapping (all two's complement):
  - x[0]=bus[3:0], x[1]=bus[7:4].
  - k[0][0]=bus[11:8], k[0][1]=bus[15:12].
  - k[1][0]=bus[19:16], k[1][1]=bus[23:20].
- Compute:
  - y[r] = sum over c of k[r][c]*x[c], signed, full W_Y = 9-bit precision.
  - Transmitted value is y[r][7:0] (wrap truncation, no saturation); e.g. 128 -> 0x80.
  - Result is registered at most 2 clocks after packet completion.
- Result buffer:
  - One entry holding {y1[7:0], y0[7:0]}.
  - Loaded on completion; a new result overwrites an unsent one.
- TX path:
  - When idle and the buffer is full: take the buffer, mark it empty, send byte y0 then byte y1.
  - Frame per byte: start 0, 8 data bits LSB first, 4 bits of 1. Each bit held exactly CLOCKS_PER_PULSE clocks.
  - tx is registered. First start bit begins within 4 clocks of buffer load.
- Concurrency: RX and TX run independently; reception of the next packet during TX is required.

Decomposition:
- Package uart_mvm_pkg holds:
  - parameter defaults and derived widths (W_Y, W_BUS_KX, N_WORDS_KX, N_WORDS_Y);
  - typedefs for signed x/k/y element arrays;
  - RX and TX state enums.
- One sub-module: uart_rx (synchronizer, bit timing, byte-valid strobe).
- TX serializer, byte assembly and MVM arithmetic stay in the top.

Test Plan:
- Bytes 0x21,0x43,0x65 -> TX bytes 0x0B then 0x11.
- Bytes 0x1F,0x32,0x7E (x=-1,1; k=[2,3],[-2,7]) -> TX 0x01, 0x09.
- Bytes 0x88,0x88,0x88 (all -8) -> y=128 each, TX 0x80, 0x80 (truncation).
- 10 random packets:
  - random 1-20 clock gaps between bytes and 1-100 clock gaps between packets;
  - each result matches the software model;
  - each TX frame's 4 trailing bits read 1.
- Byte with stop bit forced 0, then three valid bytes 0x21,0x43,0x65 -> bad byte discarded, TX 0x0B, 0x11.
- rst pulsed after 2 bytes, then 0x21,0x43,0x65 -> tx held 1 through reset; single result 0x0B, 0x11.
